// File: rtl/event_fifo_if.sv
// Frame handshake between capture (write side) and SPI readout (read side).
// master drives writes and pops; slave is the FIFO.
interface event_fifo_if #(
    parameter int FRAME_W = 128,
    parameter int DEPTH   = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               wr_en;
    logic [FRAME_W-1:0] wr_frame;
    logic               rd_done;
    logic [FRAME_W-1:0] rd_frame;
    logic               rd_valid;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               veto;
    logic               frame_dropped;
    logic [15:0]        overflow_count;

    modport master (
        output wr_en, wr_frame, rd_done,
        input  rd_frame, rd_valid, count, full, veto, frame_dropped, overflow_count
    );

    modport slave (
        input  wr_en, wr_frame, rd_done,
        output rd_frame, rd_valid, count, full, veto, frame_dropped, overflow_count
    );
endinterface

// File: rtl/event_fifo.sv
// Show-ahead event frame FIFO between trigger capture and SPI readout.
// Head frame is registered and held stable until the serializer pops it.
module event_fifo #(
    parameter int FRAME_W     = 128,
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = 6
) (
    input logic        sampling_clk,
    input logic        reset,
    event_fifo_if.slave fifo
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [FRAME_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0]   count_q, count_nxt;
    logic               rd_valid_q, dropped_q;
    logic [FRAME_W-1:0] rd_frame_q;
    logic [15:0]        ovf_q;

    logic               pop, push, drop, head_valid_nxt;
    logic [FRAME_W-1:0] head_nxt;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        pop            = fifo.rd_done && rd_valid_q;
        push           = fifo.wr_en && ((count_q != CNT_W'(DEPTH)) || pop);
        drop           = fifo.wr_en && !push;
        rd_ptr_nxt     = rd_ptr + PTR_W'(pop);
        count_nxt      = count_q + CNT_W'(push) - CNT_W'(pop);
        head_valid_nxt = (count_q != '0);
        head_nxt       = mem[rd_ptr];
        // On a pop the successor is already in memory, unless the only frame left is
        // the one being written this very edge; that one is forwarded straight in.
        if (pop) begin
            head_valid_nxt = (count_nxt != '0);
            head_nxt       = (count_q == CNT_W'(1)) ? fifo.wr_frame : mem[rd_ptr_nxt];
        end
    end

    // NOTE: frame storage is not reset; count and rd_valid already mark it as empty.
    always_ff @(posedge sampling_clk) begin
        if (push && !reset) mem[wr_ptr] <= fifo.wr_frame;
    end

    always_ff @(posedge sampling_clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_frame_q <= '0;
            dropped_q  <= 1'b0;
            ovf_q      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr     <= rd_ptr_nxt;
            count_q    <= count_nxt;
            rd_valid_q <= head_valid_nxt;
            rd_frame_q <= head_nxt;
            dropped_q  <= drop;
            if (drop && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 16'd1;
        end
    end

    assign fifo.rd_frame       = rd_frame_q;
    assign fifo.rd_valid       = rd_valid_q;
    assign fifo.count          = count_q;
    assign fifo.full           = (count_q == CNT_W'(DEPTH));
    assign fifo.veto           = (count_q >= CNT_W'(AFULL_LEVEL));
    assign fifo.frame_dropped  = dropped_q;
    assign fifo.overflow_count = ovf_q;
endmodule

// File: tb/tb_event_fifo.sv
// Self-checking bench for event_fifo: frame scoreboard plus a cycle model of
// occupancy, head validity, veto/full and overflow accounting.
module tb_event_fifo;
    localparam int FRAME_W = 128;
    localparam int DEPTH   = 8;
    localparam int AFULL   = 6;

    logic sampling_clk = 1'b0;
    logic reset;

    event_fifo_if #(.FRAME_W(FRAME_W), .DEPTH(DEPTH)) fifo_bus ();

    event_fifo #(.FRAME_W(FRAME_W), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
        .sampling_clk(sampling_clk),
        .reset       (reset),
        .fifo        (fifo_bus)
    );

    always #5 sampling_clk = ~sampling_clk;

    logic [FRAME_W-1:0] sb [$];
    int m_count;
    bit m_valid;
    bit m_drop;
    int m_ovf;
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [FRAME_W-1:0] mk(input int id);
        logic [15:0] id16;
        logic [7:0]  fill;
        id16 = id[15:0];
        fill = id[7:0] ^ 8'hA5;
        return {8'h7E, id16, {12{fill}}, 8'h7D};
    endfunction

    task automatic check_outputs();
        check("rd_valid", 128'(fifo_bus.rd_valid), 128'(m_valid));
        check("count", 128'(fifo_bus.count), 128'(m_count));
        check("full", 128'(fifo_bus.full), 128'(m_count == DEPTH));
        check("veto", 128'(fifo_bus.veto), 128'(m_count >= AFULL));
        check("frame_dropped", 128'(fifo_bus.frame_dropped), 128'(m_drop));
        check("overflow_count", 128'(fifo_bus.overflow_count), 128'(m_ovf));
        if (m_valid && sb.size() > 0) check("head_frame", fifo_bus.rd_frame, sb[0]);
    endtask

    // One clock: drive inputs, step the model, sample 1 time unit after the edge.
    task automatic cycle(input bit w, input logic [FRAME_W-1:0] f, input bit r);
        bit pop, acc, nvalid;
        pop = r && m_valid;
        acc = w && ((m_count < DEPTH) || pop);
        if (pop) begin
            if (sb.size() == 0) check("pop_nonempty", 128'(0), 128'(1));
            else begin
                check("pop_frame", fifo_bus.rd_frame, sb[0]);
                void'(sb.pop_front());
            end
        end
        fifo_bus.wr_en    = w;
        fifo_bus.wr_frame = f;
        fifo_bus.rd_done  = r;
        @(posedge sampling_clk);
        #1;
        fifo_bus.wr_en   = 1'b0;
        fifo_bus.rd_done = 1'b0;
        if (acc) sb.push_back(f);
        nvalid  = pop ? ((m_count + int'(acc) - 1) != 0) : (m_count != 0);
        m_count = m_count + int'(acc) - int'(pop);
        m_valid = nvalid;
        m_drop  = w && !acc;
        if (m_drop && m_ovf < 65535) m_ovf++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
    endtask

    task automatic do_reset(input bit w, input bit r);
        reset             = 1'b1;
        fifo_bus.wr_en    = w;
        fifo_bus.wr_frame = mk(999);
        fifo_bus.rd_done  = r;
        @(posedge sampling_clk);
        #1;
        reset            = 1'b0;
        fifo_bus.wr_en   = 1'b0;
        fifo_bus.rd_done = 1'b0;
        sb.delete();
        m_count = 0;
        m_valid = 1'b0;
        m_drop  = 1'b0;
        m_ovf   = 0;
        check_outputs();
        check("reset_rd_frame", fifo_bus.rd_frame, '0);
    endtask

    task automatic drain(input int gap);
        for (int i = 0; i < 80 && m_count > 0; i++) begin
            if (m_valid) begin
                cycle(1'b0, '0, 1'b1);
                idle(gap);
            end else cycle(1'b0, '0, 1'b0);
        end
        check("drain_count", 128'(fifo_bus.count), 128'(0));
    endtask

    initial begin
        fifo_bus.wr_en    = 1'b0;
        fifo_bus.wr_frame = '0;
        fifo_bus.rd_done  = 1'b0;
        reset             = 1'b0;
        m_count = 0;
        m_valid = 1'b0;
        m_drop  = 1'b0;
        m_ovf   = 0;
        do_reset(1'b0, 1'b0);

        // Single frame held unread: head must stay bit-stable.
        cycle(1'b1, mk(1), 1'b0);
        check("latency_not_yet_valid", 128'(fifo_bus.rd_valid), 128'(0));
        idle(50);
        check("held_frame", fifo_bus.rd_frame, mk(1));
        drain(0);

        // Three frames, pops spaced 10 cycles apart.
        for (int i = 1; i <= 3; i++) cycle(1'b1, mk(i), 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(9);
            cycle(1'b0, '0, 1'b1);
        end
        idle(2);
        check("empty_after_three", 128'(fifo_bus.rd_valid), 128'(0));

        // Veto threshold.
        for (int i = 10; i < 16; i++) cycle(1'b1, mk(i), 1'b0);
        check("veto_at_six", 128'(fifo_bus.veto), 128'(1));
        idle(1);
        cycle(1'b0, '0, 1'b1);
        check("veto_after_pop", 128'(fifo_bus.veto), 128'(0));
        drain(1);

        // Overflow: three writes discarded while full.
        for (int i = 20; i < 28; i++) cycle(1'b1, mk(i), 1'b0);
        for (int i = 90; i < 93; i++) cycle(1'b1, mk(i), 1'b0);
        check("full_after_fill", 128'(fifo_bus.full), 128'(1));
        check("ovf_three", 128'(fifo_bus.overflow_count), 128'(3));
        drain(2);

        // Write and pop together while full: accepted, count stays at DEPTH.
        for (int i = 30; i < 38; i++) cycle(1'b1, mk(i), 1'b0);
        idle(1);
        cycle(1'b1, mk(38), 1'b1);
        check("full_simul_count", 128'(fifo_bus.count), 128'(DEPTH));
        check("full_simul_no_drop", 128'(fifo_bus.frame_dropped), 128'(0));
        drain(0);
        cycle(1'b0, '0, 1'b1);
        check("pop_empty_count", 128'(fifo_bus.count), 128'(0));

        // Write coincident with pop of the last frame keeps rd_valid high.
        cycle(1'b1, mk(40), 1'b0);
        idle(2);
        cycle(1'b1, mk(41), 1'b1);
        check("handover_valid", 128'(fifo_bus.rd_valid), 128'(1));
        check("handover_frame", fifo_bus.rd_frame, mk(41));
        drain(0);

        // Reset mid-sequence with active inputs, then a fresh write.
        for (int i = 50; i < 55; i++) cycle(1'b1, mk(i), 1'b0);
        cycle(1'b0, '0, 1'b1);
        do_reset(1'b1, 1'b1);
        cycle(1'b1, mk(60), 1'b0);
        check("post_reset_count", 128'(fifo_bus.count), 128'(1));
        idle(1);
        check("post_reset_head", fifo_bus.rd_frame, mk(60));
        drain(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/event_fifo.md
Name: event_fifo

Overview:
- Frame buffer between trigger/latch capture and SPI readout.
- Accepts one assembled 128-bit event frame per sample_interrupt and presents the oldest frame to the SPI serializer in show-ahead fashion.
- Pops the oldest frame on the serializer's sample_done pulse.
- Lets triggers arrive while a readout is in progress; asserts a veto request as the buffer nears capacity and counts frames lost to overflow.

Parameters:
- FRAME_W, 128: frame width in bits (start byte through end byte).
- DEPTH, 8: number of frame slots; power of two, at least 2.
- AFULL_LEVEL, 6: occupancy at or above which veto asserts; 1 ≤ AFULL_LEVEL ≤ DEPTH.

Ports:
- sampling_clk, input, 1: PLL clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high; clears all state.
- wr_en, input, 1: single-cycle pulse from sample_interrupt; write wr_frame.
- wr_frame, input, FRAME_W: assembled frame (0x7E…0x7D); valid when wr_en is high.
- rd_done, input, 1: single-cycle pulse from the SPI sample_done; pop the head frame.
- rd_frame, output, FRAME_W: head frame, registered.
- rd_valid, output, 1: rd_frame holds an unread frame.
- count, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- full, output, 1: count == DEPTH.
- veto, output, 1: count ≥ AFULL_LEVEL.
- frame_dropped, output, 1: one-cycle pulse when a write is discarded.
- overflow_count, output, 16: total dropped frames; saturates.

Behaviour:
- Reset, synchronous and priority over all inputs:
  - Write and read pointers are 0 and count is 0.
  - rd_valid, full, veto and frame_dropped are 0.
  - rd_frame is all zeros and overflow_count is 0.
  - A reset mid-readout discards all stored frames. Inputs in the reset cycle are ignored.
- Storage: DEPTH×FRAME_W array (inferred RAM or registers). Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Write:
  - wr_en with count < DEPTH stores the frame at wr_ptr and increments wr_ptr.
  - wr_en with count == DEPTH and no concurrent valid pop drops the frame. frame_dropped pulses high the next cycle. overflow_count increments, holding at 0xFFFF.
- Pop:
  - rd_done with rd_valid=1 advances rd_ptr.
  - rd_done with rd_valid=0 is ignored: no pointer change, no error.
- Simultaneous wr_en and valid rd_done: both take effect and count is unchanged. This includes the full case, where the write is accepted and not dropped.
- Show-ahead output:
  - rd_frame/rd_valid are registered.
  - Latency: a write into an empty FIFO at edge N gives rd_valid=1 with that frame on rd_frame after edge N+1.
  - After a pop, the next frame appears on rd_frame one edge later. rd_valid drops in that cycle if the FIFO became empty.
  - Write into empty coincident with a pop of the last frame: the new frame appears on the following edge and rd_valid stays 1.
- Stability: rd_frame must not change while rd_valid=1 and rd_done=0. The SPI shifts directly from rd_frame, so a bit change mid-transaction is a failure.
- Status timing: count, full and veto are registered and reflect the state after the current edge's write/pop. veto is combinationally derived from the registered count only, with no input-to-output path.
- Ordering: strict FIFO, with no reordering or duplication.
- Frame contents pass through untouched; the block does not inspect or modify the start/end bytes.

Test Plan:
- Reset, then write one frame 0x7E_0001_…_7D; hold rd_done low for 50 cycles → rd_valid=1 from cycle 2, rd_frame bit-stable for all 50 cycles, count=1.
- Write 3 frames with IDs 1,2,3 back-to-back, then pulse rd_done 3 times spaced 10 cycles apart → rd_frame shows IDs 1,2,3 in order; rd_valid=0 after the third pop; count returns 0.
- With DEPTH=8 and AFULL_LEVEL=6, write 6 frames → veto=1 after the 6th write edge. Pop one → veto=0.
- Fill to 8 and write 3 more with no pops → full=1, three frame_dropped pulses, overflow_count=3. Subsequent reads return the first 8 frames unchanged.
- When full, assert wr_en and rd_done in the same cycle → no drop, count stays 8, new frame read out last. Also: rd_done while empty → count stays 0, no underflow.
- Write 5 frames, assert reset for 1 cycle mid-sequence → all outputs zero next cycle. A following write appears after 1 edge with count=1.
